// File: rtl/wave_lut_pkg.sv
// Shared types and constants for the wave_lut_pipe waveform generator,
// including the elaboration-time quarter-cosine table function.
package wave_lut_pkg;

    typedef enum logic [1:0] {
        MODE_SAW_UP = 2'b00,
        MODE_SAW_DN = 2'b01,
        MODE_SQUARE = 2'b10,
        MODE_COS    = 2'b11
    } mode_e;

    localparam int GAIN_W     = 9;
    localparam int GAIN_UNITY = 256;
    localparam int GAIN_SHIFT = $clog2(GAIN_UNITY);

    localparam longint COS_ONE = 64'sd1 <<< 30;
    localparam longint PI_Q30  = 64'sd3373259426;

    // round((2^(amp_w-1)-1) * cos(k*pi/(2n))) via a Q30 Taylor series;
    // the angle never exceeds pi/2, so ten terms are far below one LSB.
    function automatic int qcos_entry(input int k, input int n, input int amp_w);
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint scaled;
        x    = (longint'(k) * PI_Q30) / (64'sd2 * longint'(n));
        x2   = (x * x) >>> 30;
        term = COS_ONE;
        acc  = COS_ONE;
        for (int i = 1; i <= 10; i++) begin
            term = ((term * x2) >>> 30) / longint'((2 * i - 1) * (2 * i));
            acc  = (i % 2 == 1) ? acc - term : acc + term;
        end
        if (acc < 0) begin
            acc = 0;
        end
        scaled = (longint'((1 << (amp_w - 1)) - 1) * acc + (64'sd1 <<< 29)) >>> 30;
        return int'(scaled);
    endfunction

endpackage

// File: rtl/quarter_cos_lut.sv
// Quarter-period cosine ROM (N+1 entries) built at elaboration, with a
// registered read that advances only when en is high.
module quarter_cos_lut
    import wave_lut_pkg::*;
#(
    parameter int PHASE_W = 8,
    parameter int AMP_W   = 10
) (
    input  logic               clk,
    input  logic               en,
    input  logic [PHASE_W-2:0] addr,
    output logic [AMP_W-2:0]   data
);
    localparam int QN = 1 << (PHASE_W - 2);

    logic [AMP_W-2:0] rom [0:QN];
    logic [AMP_W-2:0] data_q;

    for (genvar gi = 0; gi <= QN; gi++) begin : g_rom
        localparam logic [AMP_W-2:0] ENTRY = (AMP_W-1)'(qcos_entry(gi, QN, AMP_W));
        assign rom[gi] = ENTRY;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data_q <= rom[addr];
        end
    end

    assign data = data_q;

endmodule

// File: rtl/wave_lut_pipe.sv
// Phase-to-amplitude generator: 3-stage valid/ready pipeline (decode, LUT read,
// gain/output). Define WAVE_LUT_PIPE_GAIN_EN to enable the gain multiply.
module wave_lut_pipe
    import wave_lut_pkg::*;
#(
    parameter int PHASE_W = 8,
    parameter int AMP_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PHASE_W-1:0] phase_in,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] duty,
    input  logic [GAIN_W-1:0]  gain,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [AMP_W-1:0]   amplitude
);
    localparam int SHIFT = AMP_W - PHASE_W;
    localparam int QN    = 1 << (PHASE_W - 2);
    localparam int MID   = 1 << (AMP_W - 1);

    if (PHASE_W < 4 || PHASE_W > 12) begin : g_bad_phase_w
        $error("wave_lut_pipe: PHASE_W must be within 4..12");
    end
    if (AMP_W < PHASE_W) begin : g_bad_amp_w
        $error("wave_lut_pipe: AMP_W must be >= PHASE_W");
    end

    logic ce;
    assign ce       = !out_valid || out_ready;
    assign in_ready = ce;

    logic [1:0]         quad;
    logic [PHASE_W-3:0] quad_off;
    logic [PHASE_W-1:0] phase_inv;
    logic [PHASE_W-2:0] s1_addr_d;
    logic               s1_neg_d;
    logic               s1_cos_d;
    logic [AMP_W-1:0]   s1_raw_d;

    // Odd quadrants walk the quarter table backwards (index N-a); quadrants
    // 1 and 2 sit below mid-scale.
    always_comb begin
        quad      = phase_in[PHASE_W-1 -: 2];
        quad_off  = phase_in[PHASE_W-3:0];
        phase_inv = ~phase_in;
        s1_neg_d  = quad[0] ^ quad[1];
        s1_addr_d = quad[0] ? (PHASE_W-1)'(QN) - {1'b0, quad_off} : {1'b0, quad_off};
        s1_cos_d  = 1'b0;
        s1_raw_d  = '0;
        case (mode_e'(mode))
            MODE_SAW_UP: s1_raw_d = AMP_W'(phase_in) << SHIFT;
            MODE_SAW_DN: s1_raw_d = AMP_W'(phase_inv) << SHIFT;
            MODE_SQUARE: s1_raw_d = (phase_in < duty) ? '1 : '0;
            default:     s1_cos_d = 1'b1;
        endcase
    end

    logic               s1_valid_q, s2_valid_q, s3_valid_q;
    logic               s1_cos_q, s2_cos_q;
    logic               s1_neg_q, s2_neg_q;
    logic [AMP_W-1:0]   s1_raw_q, s2_raw_q;
    logic [PHASE_W-2:0] s1_addr_q;
    logic [AMP_W-2:0]   s2_lut;
    logic [AMP_W-1:0]   s2_amp;
    logic [AMP_W-1:0]   s3_amp_d, s3_amp_q;
`ifdef WAVE_LUT_PIPE_GAIN_EN
    logic [GAIN_W-1:0]  s1_gain_q, s2_gain_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_amp_q   <= '0;
        end else if (ce) begin
            s1_valid_q <= in_valid;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
            s3_amp_q   <= s3_amp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            s1_cos_q  <= s1_cos_d;
            s1_neg_q  <= s1_neg_d;
            s1_raw_q  <= s1_raw_d;
            s1_addr_q <= s1_addr_d;
            s2_cos_q  <= s1_cos_q;
            s2_neg_q  <= s1_neg_q;
            s2_raw_q  <= s1_raw_q;
`ifdef WAVE_LUT_PIPE_GAIN_EN
            s1_gain_q <= gain;
            s2_gain_q <= s1_gain_q;
`endif
        end
    end

    quarter_cos_lut #(
        .PHASE_W (PHASE_W),
        .AMP_W   (AMP_W)
    ) u_lut (
        .clk  (clk),
        .en   (ce),
        .addr (s1_addr_q),
        .data (s2_lut)
    );

    always_comb begin
        if (!s2_cos_q) begin
            s2_amp = s2_raw_q;
        end else if (s2_neg_q) begin
            s2_amp = AMP_W'(MID) - AMP_W'(s2_lut);
        end else begin
            s2_amp = AMP_W'(MID) + AMP_W'(s2_lut);
        end
    end

`ifdef WAVE_LUT_PIPE_GAIN_EN
    localparam int PROD_W = AMP_W + GAIN_W;

    logic [PROD_W-1:0]            prod;
    logic [PROD_W-GAIN_SHIFT-1:0] prod_scaled;

    assign prod        = PROD_W'(s2_amp) * PROD_W'(s2_gain_q);
    assign prod_scaled = prod[PROD_W-1:GAIN_SHIFT];
    assign s3_amp_d    = (|prod_scaled[PROD_W-GAIN_SHIFT-1:AMP_W]) ? '1 : prod_scaled[AMP_W-1:0];
`else
    logic unused_gain;
    assign unused_gain = ^gain;
    assign s3_amp_d    = s2_amp;
`endif

    assign out_valid = s3_valid_q;
    assign amplitude = s3_amp_q;

endmodule

// File: tb/tb_wave_lut_pipe.sv
// Scoreboard bench for wave_lut_pipe (PHASE_W=8, AMP_W=10); expectations follow
// the WAVE_LUT_PIPE_GAIN_EN setting of the build.
`timescale 1ns/1ps
module tb_wave_lut_pipe;
    import wave_lut_pkg::*;

`ifdef WAVE_LUT_PIPE_GAIN_EN
    localparam bit GAIN_EN = 1'b1;
`else
    localparam bit GAIN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] phase_in;
    logic [1:0] mode;
    logic [7:0] duty;
    logic [8:0] gain;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] amplitude;

    always #5 clk = ~clk;

    wave_lut_pipe #(.PHASE_W(8), .AMP_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .phase_in  (phase_in),
        .mode      (mode),
        .duty      (duty),
        .gain      (gain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .amplitude (amplitude)
    );

    typedef struct {
        int amp;
        int acc;
        bit chk_lat;
        int id;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   next_id = 0;
    bit   rnd_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic int pick(input int with_gain, input int without_gain);
        return GAIN_EN ? with_gain : without_gain;
    endfunction

    // Independent reference for the non-cosine waveforms.
    function automatic int model(input int m, input int ph, input int du, input int g);
        int raw;
        int v;
        case (m)
            0:       raw = ph * 4;
            1:       raw = (255 - ph) * 4;
            default: raw = (ph < du) ? 1023 : 0;
        endcase
        v = (raw * g) / 256;
        if (v > 1023) v = 1023;
        return pick(v, raw);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic send(input int m, input int ph, input int du, input int g,
                        input int ev, input bit cl);
        int   waits = 0;
        exp_t e;
        mode     = 2'(m);
        phase_in = 8'(ph);
        duty     = 8'(du);
        gain     = 9'(g);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waits);
        end else begin
            e.amp     = ev;
            e.acc     = cyc;
            e.chk_lat = cl;
            e.id      = next_id;
            next_id++;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d outputs still pending, required 0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every handshake and checks hold behaviour while stalled.
    initial begin
        bit         prev_stall = 1'b0;
        logic [9:0] prev_amp = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    total++;
                    if (out_valid !== 1'b1 || amplitude !== prev_amp) begin
                        bad++;
                        $display("FAIL stall_hold: out_valid=%0b amplitude=%0d required out_valid=1 amplitude=%0d",
                                 out_valid, amplitude, prev_amp);
                    end
                end
                if (out_valid && out_ready) begin
                    total++;
                    if (sb_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_out: amplitude=%0d with no beat outstanding", amplitude);
                    end else begin
                        e = sb_q.pop_front();
                        if (amplitude !== 10'(e.amp)) begin
                            bad++;
                            $display("FAIL beat_%0d: amplitude=%0d required %0d", e.id, amplitude, e.amp);
                        end else begin
                            $display("out beat=%0d amplitude=%0d expected=%0d", e.id, amplitude, e.amp);
                        end
                        if (e.chk_lat) begin
                            total++;
                            if (cyc - e.acc != 3) begin
                                bad++;
                                $display("FAIL latency_%0d: %0d cycles, required 3", e.id, cyc - e.acc);
                            end
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_amp   = amplitude;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        phase_in  = '0;
        mode      = '0;
        duty      = '0;
        gain      = 9'd256;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_amplitude", amplitude, 0);
        chk("reset_in_ready", in_ready, 1);

        // Cosine quarter points back-to-back, latency checked.
        send(MODE_COS, 0,   0, 256, 1023, 1'b1);
        send(MODE_COS, 64,  0, 256, 512,  1'b1);
        send(MODE_COS, 128, 0, 256, 1,    1'b1);
        send(MODE_COS, 192, 0, 256, 512,  1'b1);
        drain();

        // Interior cosine points: T[16]=472, T[32]=361.
        send(MODE_COS, 16,  0, 256, 984, 1'b0);
        send(MODE_COS, 32,  0, 256, 873, 1'b0);
        send(MODE_COS, 96,  0, 256, 151, 1'b0);
        send(MODE_COS, 160, 0, 256, 151, 1'b0);
        send(MODE_COS, 224, 0, 256, 873, 1'b0);
        send(MODE_COS, 0,   0, 128, pick(511, 1023), 1'b0);

        // Saw / square boundaries, then gain and saturation.
        send(MODE_SAW_UP, 255, 0,   256, 1020, 1'b0);
        send(MODE_SAW_DN, 0,   0,   256, 1020, 1'b0);
        send(MODE_SQUARE, 127, 128, 256, 1023, 1'b0);
        send(MODE_SQUARE, 128, 128, 256, 0,    1'b0);
        send(MODE_SQUARE, 0,   0,   256, 0,    1'b0);
        send(MODE_SQUARE, 255, 0,   256, 0,    1'b0);
        send(MODE_SAW_UP, 200, 0,   511, pick(1023, 800), 1'b0);
        send(MODE_SAW_UP, 200, 0,   128, pick(400, 800),  1'b0);
        send(MODE_SAW_UP, 200, 0,   0,   pick(0, 800),    1'b0);
        send(MODE_SAW_DN, 100, 0,   384, pick(930, 620),  1'b0);
        drain();

        // 20-beat stream under random backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(i % 3, (i * 37) % 256, 100, 128 + i * 20,
                 model(i % 3, (i * 37) % 256, 100, 128 + i * 20), 1'b0);
        end
        drain();
        rnd_ready = 1'b0;
        out_ready = 1'b0;

        // Three beats in flight behind a stall, then reset.
        send(MODE_SAW_UP, 10, 0, 256, 40,  1'b0);
        send(MODE_SAW_UP, 20, 0, 256, 80,  1'b0);
        send(MODE_SAW_UP, 30, 0, 256, 120, 1'b0);
        rst = 1'b1;
        sb_q.delete();
        in_valid = 1'b1;
        phase_in = 8'd50;
        @(posedge clk);
        #1;
        chk("rst_flush_out_valid", out_valid, 0);
        chk("rst_flush_amplitude", amplitude, 0);
        in_valid = 1'b0;
        rst = 1'b0;
        chk("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_stale_out_valid", out_valid, 0);

        // Pipeline still works after reset.
        send(MODE_SAW_UP, 255, 0, 256, 1020, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_lut_pipe.md
WAVE_LUT_PIPE -- requirements
Module: wave_lut_pipe

Interface
REQ-001 SHALL have parameter PHASE_W, default 8, phase input width; legal range 4..12.
REQ-002 SHALL have parameter AMP_W, default 10, amplitude output width; AMP_W >= PHASE_W, elaboration error otherwise.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  phase beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port phase_in  input  PHASE_W  phase, 0..2^PHASE_W-1 maps to one period.
REQ-008 SHALL have port mode  input  2  waveform, sampled with the beat: 00 saw-up, 01 saw-down, 10 square, 11 cosine.
REQ-009 SHALL have port duty  input  PHASE_W  square high threshold, sampled with the beat.
REQ-010 SHALL have port gain  input  9  amplitude gain, 256 = unity, sampled with the beat.
REQ-011 SHALL have port out_valid  output  1  amplitude valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts.
REQ-013 SHALL have port amplitude  output  AMP_W  unsigned sample, 0..2^AMP_W-1.

Function
REQ-014 SHALL be a 3-stage pipeline: S1 decode/register, S2 LUT read, S3 gain/output register; latency exactly 3 cycles from accepted beat to out_valid with out_ready held high.
REQ-015 SHALL advance all stages when ce = !out_valid || out_ready; in_ready = ce; a beat is accepted when in_valid && in_ready.
REQ-016 SHALL hold amplitude and out_valid stable while out_valid && !out_ready; no beat lost or duplicated; throughput 1 beat/cycle.
REQ-017 SHALL, per stage, carry a valid bit; invalid stages are bubbles and still advance on ce.
REQ-018 saw-up SHALL give raw = phase_in << (AMP_W-PHASE_W).
REQ-019 saw-down SHALL give raw = (2^PHASE_W-1 - phase_in) << (AMP_W-PHASE_W).
REQ-020 square SHALL give raw = 2^AMP_W-1 when phase_in < duty, else 0; duty=0 gives constant 0.
REQ-021 cosine SHALL use quarter table T of N+1 entries, N = 2^(PHASE_W-2), T[k] = round((2^(AMP_W-1)-1)*cos(k*pi/(2N))); a = phase_in[PHASE_W-3:0], M = 2^(AMP_W-1).
REQ-022 cosine quadrant 0 SHALL give M+T[a]; quadrant 1 M-T[N-a]; quadrant 2 M-T[a]; quadrant 3 M+T[N-a].
REQ-023 SHALL compute out = (raw*gain)>>8 at full precision, saturated to 2^AMP_W-1.
REQ-024 mode, duty, gain changes SHALL affect only beats accepted after the change; in-flight beats keep sampled values.

Reset
REQ-025 rst high SHALL clear all stage valid bits, amplitude=0, out_valid=0 on the next edge.
REQ-026 SHALL ignore in_valid during rst; in_ready=1 in the cycle after rst deasserts.
REQ-027 rst mid-operation SHALL discard all in-flight beats; none emerges afterwards.

Configuration
REQ-028 Macro WAVE_LUT_PIPE_GAIN_EN defined: gain multiply and saturation per REQ-023.
REQ-029 Macro WAVE_LUT_PIPE_GAIN_EN undefined: gain port present but ignored, out = raw, no multiplier inferred; latency still 3 cycles.

Structure
REQ-030 Package wave_lut_pkg SHALL hold mode enum (MODE_SAW_UP, MODE_SAW_DN, MODE_SQUARE, MODE_COS), GAIN_W=9, GAIN_UNITY=256, and the elaboration-time quarter-cosine table function.
REQ-031 Sub-module quarter_cos_lut SHALL hold T with registered read (1 cycle), parameters PHASE_W, AMP_W; table computed at elaboration.

Verification (PHASE_W=8, AMP_W=10, macro defined)
REQ-032 cosine, gain=256, phase 0,64,128,192 back-to-back, out_ready=1 -> amplitude 1023,512,1,512 on cycles 3..6 after first beat.
REQ-033 saw-up phase 255 gain 256 -> 1020; saw-down phase 0 -> 1020; square duty=128 phase 127/128 -> 1023/0; duty=0 -> 0.
REQ-034 saw-up phase 200 gain 511 -> 1023 (saturated); gain 128 -> 400; gain 0 -> 0.
REQ-035 stream of 20 beats, out_ready toggled pseudo-randomly -> all 20 outputs in order, values match model, amplitude stable while stalled.
REQ-036 rst asserted with 3 beats in flight -> out_valid=0 next cycle, no stale beat after release, in_ready=1.
REQ-037 macro undefined, saw-up phase 200 gain 0 -> 800.
